count_ctrl: RTL and testbench

//   Run/pause/clear sequencer for the 4-bit display counter feeding bin2dec/hex7segment.

---
 rtl/count_ctrl_pkg.sv | 17 +
 rtl/count_ctrl_btn_cond.sv | 64 ++++++
 rtl/count_ctrl.sv | 128 ++++++++++++
 tb/tb_count_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the count_ctrl sequencer.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int unsigned COUNT_W = 4;

    // Prescaler width for a 0..div-1 counter; never narrower than one bit.
    function automatic int presc_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/count_ctrl_btn_cond.sv
// Button conditioning: 2-flop synchronizer, rising-edge one-shot command pulse.
// With DEBOUNCE_EN defined, a stability filter sits between synchronizer and edge detector.
module count_ctrl_btn_cond
`ifdef DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYC = 500_000
)
`endif
(
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_raw,
    output logic cmd
);

    logic sync_meta;
    logic sync_lvl;
    logic level;
    logic level_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_lvl  <= sync_meta;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] stable_cnt;

    // The filtered level only flips after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (sync_lvl == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            stable_cnt <= '0;
            level      <= sync_lvl;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync_lvl;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign cmd = level & ~level_d;

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear sequencer driving a bounded 4-bit up/down display counter.
// Define DEBOUNCE_EN to add the DEBOUNCE_CYC stability filter on both buttons.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned MAX_VAL = 9
`ifdef DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYC = 500_000
`endif
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               btn_run,
    input  logic               btn_clr,
    input  logic               up_down,
    output logic [COUNT_W-1:0] count,
    output logic               tick,
    output logic               wrap,
    output logic               running
);

    localparam int unsigned        DIV        = CLK_HZ / TICK_HZ;
    localparam int                 PW         = presc_width(DIV);
    localparam logic [PW-1:0]      PRESC_LAST = PW'(DIV - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT    = COUNT_W'(MAX_VAL);

    state_t             state;
    state_t             state_next;
    logic [PW-1:0]      presc;
    logic               run_cmd;
    logic               clr_cmd;
    logic               ud_meta;
    logic               ud_sync;
    logic               tick_now;
    logic               wrap_now;
    logic [COUNT_W-1:0] count_next;

    count_ctrl_btn_cond
`ifdef DEBOUNCE_EN
        #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
`endif
    u_run_btn (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .btn_raw (btn_run),
        .cmd     (run_cmd)
    );

    count_ctrl_btn_cond
`ifdef DEBOUNCE_EN
        #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
`endif
    u_clr_btn (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .btn_raw (btn_clr),
        .cmd     (clr_cmd)
    );

    // Clear outranks run/pause, and also suppresses a tick landing in the same cycle.
    always_comb begin
        state_next = state;
        tick_now   = 1'b0;
        wrap_now   = 1'b0;
        count_next = count;

        if (clr_cmd) begin
            state_next = ST_IDLE;
        end else if (run_cmd) begin
            case (state)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   state_next = ST_PAUSE;
                ST_PAUSE: state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end

        if (state == ST_RUN && presc == PRESC_LAST && !clr_cmd) begin
            tick_now = 1'b1;
            if (ud_sync) begin
                if (count == MAX_CNT) begin
                    count_next = '0;
                    wrap_now   = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_next = MAX_CNT;
                    wrap_now   = 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    // Prescaler holds in PAUSE so a resumed run keeps its tick phase.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            presc   <= '0;
            count   <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
            ud_meta <= 1'b0;
            ud_sync <= 1'b0;
        end else begin
            ud_meta <= up_down;
            ud_sync <= ud_meta;
            state   <= state_next;
            running <= (state_next == ST_RUN);
            tick    <= tick_now;
            wrap    <= wrap_now;
            count   <= clr_cmd ? '0 : count_next;
            if (clr_cmd || state == ST_IDLE) begin
                presc <= '0;
            end else if (state == ST_RUN) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl at CLK_HZ=8, TICK_HZ=1, MAX_VAL=9 (DIV=8).
module tb_count_ctrl;

    localparam int DIV  = 8;
    localparam int MAXV = 9;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 7;
    localparam int HOLD = 6;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif

    typedef struct {
        int         at;
        logic [3:0] cnt;
        logic       wr;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       btn_run;
    logic       btn_clr;
    logic       up_down;
    logic [3:0] count;
    logic       tick;
    logic       wrap;
    logic       running;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    count_ctrl #(
        .CLK_HZ  (8),
        .TICK_HZ (1),
        .MAX_VAL (MAXV)
`ifdef DEBOUNCE_EN
        ,
        .DEBOUNCE_CYC (4)
`endif
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .up_down (up_down),
        .count   (count),
        .tick    (tick),
        .wrap    (wrap),
        .running (running)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every tick the DUT presents is matched against the next queued expectation.
    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (tick === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_tick: got tick at cyc=%0d count=%0d wrap=%0b, want no tick",
                         cyc, count, wrap);
            end else begin
                e = expq.pop_front();
                if (e.at != cyc || count !== e.cnt || wrap !== e.wr) begin
                    errors++;
                    $display("[TB] FAIL tick_value: got cyc=%0d count=%0d wrap=%0b, want cyc=%0d count=%0d wrap=%0b",
                             cyc, count, wrap, e.at, e.cnt, e.wr);
                end
            end
        end
    end

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic run, input logic clr, input int hold);
        btn_run = run;
        btn_clr = clr;
        waitCycle(cyc + hold);
        btn_run = 1'b0;
        btn_clr = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ec, input logic er,
                               input logic et, input logic ew);
        checks++;
        if (count !== ec || running !== er || tick !== et || wrap !== ew) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d running=%0b tick=%0b wrap=%0b, want count=%0d running=%0b tick=%0b wrap=%0b",
                     name, count, running, tick, wrap, ec, er, et, ew);
        end
    endtask

    // Queue n ticks DIV cycles apart starting at cycle 'first', counting from 'start'.
    task automatic pushTicks(input int first, input int n, input logic [3:0] start, input logic up);
        logic [3:0] c;
        logic       w;
        c = start;
        for (int i = 0; i < n; i++) begin
            if (up) begin
                w = (c == 4'(MAXV));
                c = w ? 4'd0 : c + 4'd1;
            end else begin
                w = (c == 4'd0);
                c = w ? 4'(MAXV) : c - 4'd1;
            end
            expq.push_back('{first + DIV * i, c, w});
        end
    endtask

    task automatic clearAndCheck(input string name);
        int c0;
        c0 = cyc;
        applyStimulus(1'b0, 1'b1, HOLD);
        waitCycle(c0 + LAT + 2);
        checkOutput(name, 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(cyc + 12);
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("[TB] FAIL timeout: got no end of stimulus by cyc=%0d, want completion", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int p;
        int t0;
        rst_n   = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        up_down = 1'b1;
        waitCycle(3);
        checkOutput("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        waitCycle(cyc + 4);
        checkOutput("after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] up count with wrap");
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 10, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(p + LAT - 1);
        checkOutput("run_latency_before", 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(p + LAT);
        checkOutput("run_latency_at", 4'd0, 1'b1, 1'b0, 1'b0);
        waitCycle(t0 + 73);
        checkOutput("up_wrapped", 4'd0, 1'b1, 1'b0, 1'b0);
        clearAndCheck("up_cleared");

        $display("[TB] down count with wrap");
        up_down = 1'b0;
        waitCycle(cyc + 3);
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 3, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 17);
        checkOutput("down_count", 4'd7, 1'b1, 1'b0, 1'b0);
        clearAndCheck("down_cleared");
        up_down = 1'b1;
        waitCycle(cyc + 3);

        $display("[TB] pause and resume");
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 4, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 30 - LAT);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 31);
        checkOutput("paused", 4'd4, 1'b0, 1'b0, 1'b0);
        waitCycle(t0 + 50);
        checkOutput("pause_hold", 4'd4, 1'b0, 1'b0, 1'b0);
        pushTicks(t0 + 72, 2, 4'd4, 1'b1);
        waitCycle(t0 + 70 - LAT);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 71);
        checkOutput("resumed", 4'd4, 1'b1, 1'b0, 1'b0);
        waitCycle(t0 + 81);
        checkOutput("resume_count", 4'd6, 1'b1, 1'b0, 1'b0);
        clearAndCheck("pause_cleared");

        $display("[TB] run and clear together on a tick cycle");
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 6, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 41);
        checkOutput("count_six", 4'd6, 1'b1, 1'b0, 1'b0);
        waitCycle(t0 + 48 - LAT);
        applyStimulus(1'b1, 1'b1, HOLD);
        waitCycle(t0 + 48);
        checkOutput("clr_beats_tick", 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(t0 + 64);
        checkOutput("clr_stays_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(cyc + 12);

        $display("[TB] held run button");
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 12, 4'd0, 1'b1);
        btn_run = 1'b1;
        waitCycle(p + 50);
        checkOutput("hold_run_mid", 4'd5, 1'b1, 1'b0, 1'b0);
        waitCycle(t0 + 89);
        checkOutput("hold_run_end", 4'd2, 1'b1, 1'b0, 1'b0);
        btn_run = 1'b0;
        clearAndCheck("hold_cleared");

        $display("[TB] asynchronous reset mid-run");
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 2, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, HOLD);
        waitCycle(t0 + 10);
        checkOutput("before_async_reset", 4'd2, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(cyc + 1);
        rst_n = 1'b1;
        waitCycle(cyc + 12);
        checkOutput("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef DEBOUNCE_EN
        $display("[TB] debounce filter");
        applyStimulus(1'b1, 1'b0, 2);
        waitCycle(cyc + 12);
        checkOutput("glitch_ignored", 4'd0, 1'b0, 1'b0, 1'b0);
        p  = cyc;
        t0 = p + LAT + DIV;
        pushTicks(t0, 1, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("debounce_before", 4'd0, 1'b0, 1'b0, 1'b0);
        waitCycle(p + 7);
        checkOutput("debounce_run", 4'd0, 1'b1, 1'b0, 1'b0);
        waitCycle(t0 + 1);
        clearAndCheck("debounce_cleared");
`endif

        waitCycle(cyc + 20);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_ticks: got %0d ticks still outstanding, want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
